// File: rtl/fifo_umbral_if.sv
// Queue-side bundle for one fifo_umbral instance: push/pop handshake, data,
// live threshold pair from the link FSM, and the status flags returned to it.
interface fifo_umbral_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [4:0]            umbral_low;
    logic [4:0]            umbral_high;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  error;

    modport master (
        output push, pop, data_in, umbral_low, umbral_high,
        input  data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );

    modport slave (
        input  push, pop, data_in, umbral_low, umbral_high,
        output data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );
endinterface

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-empty/almost-full thresholds and a sticky
// overflow/underflow error bit. Memory has no reset; only control state does.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  q
);
    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  error;

    logic empty, full;
    logic push_ok, pop_ok;
    logic overflow, underflow;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A full FIFO still takes a push when the same edge frees a slot; an empty
    // FIFO never forwards a same-cycle push to the reader.
    assign pop_ok    = q.pop && !empty;
    assign push_ok   = q.push && (!full || pop_ok);
    assign overflow  = q.push && full && !pop_ok;
    assign underflow = q.pop && empty;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= q.data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;

            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            valid_out <= pop_ok;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (overflow || underflow)
                error <= 1'b1;
        end
    end

    // Thresholds are 5 bits and compared unsigned, so out-of-range settings
    // naturally pin the flags (high > depth never fires, high == 0 always does).
    assign q.almost_empty = (32'(count) <= 32'(q.umbral_low));
    assign q.almost_full  = (32'(count) >= 32'(q.umbral_high));

    assign q.empty     = empty;
    assign q.full      = full;
    assign q.count     = count;
    assign q.data_out  = data_out;
    assign q.valid_out = valid_out;
    assign q.error     = error;
endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral: a queue model predicts every flag and
// popped word cycle by cycle, including the asynchronous mid-cycle reset.
module tb_fifo_umbral;
    localparam int DW    = 6;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) q();
    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int c;
        c = sb.size();
        chk({ph, " count"},     32'(q.count), c);
        chk({ph, " empty"},     32'(q.empty), 32'(c == 0));
        chk({ph, " full"},      32'(q.full), 32'(c == DEPTH));
        chk({ph, " almost_e"},  32'(q.almost_empty), 32'(c <= int'(q.umbral_low)));
        chk({ph, " almost_f"},  32'(q.almost_full), 32'(c >= int'(q.umbral_high)));
        chk({ph, " error"},     32'(q.error), 32'(m_err));
        chk({ph, " valid_out"}, 32'(q.valid_out), 32'(m_vld));
        chk({ph, " data_out"},  32'(q.data_out), 32'(m_dout));
    endtask

    task automatic step(input logic ps, input logic pp, input logic [DW-1:0] d, input string ph);
        bit mp, mw;
        q.push    = ps;
        q.pop     = pp;
        q.data_in = d;
        mp = pp && (sb.size() > 0);
        mw = ps && ((sb.size() < DEPTH) || mp);
        if ((ps && !mw) || (pp && !mp))
            m_err = 1'b1;
        m_vld = mp;
        if (mp) m_dout = sb.pop_front();
        if (mw) sb.push_back(d);
        @(posedge clk);
        #1;
        q.push = 1'b0;
        q.pop  = 1'b0;
        check_all(ph);
    endtask

    task automatic model_clear();
        sb.delete();
        m_err  = 1'b0;
        m_vld  = 1'b0;
        m_dout = '0;
    endtask

    task automatic do_reset(input string ph);
        reset = 1'b0;
        model_clear();
        #1;
        check_all(ph);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        q.push        = 1'b0;
        q.pop         = 1'b0;
        q.data_in     = '0;
        q.umbral_low  = 5'd3;
        q.umbral_high = 5'd12;
        reset         = 1'b0;
        model_clear();

        do_reset("rst");

        // fill, almost_full at 12, full at 16, then dropped 17th word
        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, DW'(i), "fill");
        step(1'b1, 1'b0, 6'h3F, "ovf");

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, '0, "drain");

        step(1'b0, 1'b1, '0, "udf");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, DW'(8'h20 + i), "sticky");

        do_reset("rst2");
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, DW'(i + 17), "fill2");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, DW'(i + 40), "pp_full");
        while (sb.size() > 0)
            step(1'b0, 1'b1, '0, "drain2");
        step(1'b1, 1'b1, 6'h2A, "pp_empty");

        do_reset("rst3");
        for (int i = 0; i < 320; i++) begin
            logic ps, pp;
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 50);
            step(ps, pp, DW'($urandom_range(0, 63)), "wrap");
        end
        while (sb.size() > 7)
            step(1'b0, 1'b1, '0, "to7");
        while (sb.size() < 7)
            step(1'b1, 1'b0, DW'($urandom_range(0, 63)), "to7");

        // reset asserted between edges must clear outputs without a clock
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check_all("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, '0, "udf_post_rst");

        do_reset("rst4");
        q.umbral_high = 5'd0;
        q.umbral_low  = 5'd20;
        #1;
        check_all("thr_zero");
        q.umbral_high = 5'd17;
        q.umbral_low  = 5'd16;
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, DW'(i), "thr_hi");
        q.umbral_high = 5'd16;
        #1;
        check_all("thr_16");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
